sram_chip_model: RTL

Synthesizable clocked stand-in for the external 16-bit asynchronous SRAM, driven from the pin side of the `sram` controller. It sits opposite the controller, with `address`/`OE`/`CS`/`WE`/data pins in and `data_pins_in` out. Simulation benches and the FPGA loopback build exercise `sram` and `pixel_buffer` against it without the board chip. The array is a reduced-depth, address-aliased RAM with programmable read latency and end-of-write commit semantics.

---
 rtl/sram_chip_model.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sram_chip_model.sv
// Clocked stand-in for the external 16-bit async SRAM: aliased array, READ_LAT read pipeline,
// end-of-window write commit. Define SRAM_MODEL_CHECK_EN to compile in the protocol checker.
module sram_chip_model #(
   parameter int DEPTH_W  = 12,
   parameter int READ_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [17:0] address,
   input  logic [15:0] data_pins_out,
   input  logic        data_pins_out_en,
   input  logic        OE,
   input  logic        CS,
   input  logic        WE,
   output logic [15:0] data_pins_in,
   output logic        contention,
   output logic [7:0]  err_count
);

   localparam int WORDS = 1 << DEPTH_W;

   logic [15:0]        mem_q [WORDS];
   logic               win_s;
   logic               read_s;
   logic               commit_s;
   logic               mem_we_s;
   logic               bypass_s;
   logic [DEPTH_W-1:0] rd_addr_s;
   logic [15:0]        rd_data_s;

   logic               win_prev_q;
   logic               pend_valid_q, pend_valid_d;
   logic [DEPTH_W-1:0] pend_addr_q, pend_addr_d;
   logic [15:0]        pend_data_q, pend_data_d;

   logic [READ_LAT-1:0] pipe_vld_q;
   logic [15:0]         pipe_dat_q [READ_LAT];
   logic [15:0]         dout_q;

   logic unused_addr_s;
   assign unused_addr_s = ^address[17:DEPTH_W];

   // Decode the pin state, commit detection and the write-first read mux.
   always_comb begin
      win_s        = !CS && !WE;
      read_s       = !CS && !OE && WE;
      commit_s     = win_prev_q && !win_s;
      mem_we_s     = commit_s && pend_valid_q;
      rd_addr_s    = address[DEPTH_W-1:0];
      bypass_s     = mem_we_s && (pend_addr_q == rd_addr_s);
      rd_data_s    = bypass_s ? pend_data_q : mem_q[rd_addr_s];
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      if (win_s && data_pins_out_en) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = rd_addr_s;
         pend_data_d  = data_pins_out;
      end else if (commit_s) begin
         pend_valid_d = 1'b0;
      end else begin
         pend_valid_d = pend_valid_q;
      end
   end

   // Write-window tracking and pending word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_prev_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= 16'h0000;
      end else begin
         win_prev_q   <= win_s;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
      end
   end

   // Array contents survive reset on purpose, so the array has no reset branch.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[pend_addr_q] <= pend_data_q;
      end
   end

   // Read latency pipeline feeding a registered, zero-when-idle output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_vld_q <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            pipe_dat_q[i] <= 16'h0000;
         end
         dout_q <= 16'h0000;
      end else begin
         pipe_vld_q[0] <= read_s;
         pipe_dat_q[0] <= rd_data_s;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_dat_q[i] <= pipe_dat_q[i-1];
         end
         dout_q <= pipe_vld_q[READ_LAT-1] ? pipe_dat_q[READ_LAT-1] : 16'h0000;
      end
   end

   assign data_pins_in = dout_q;

`ifdef SRAM_MODEL_CHECK_EN
   logic       contention_q, contention_d;
   logic [7:0] err_q, err_d;
   logic [1:0] ev_s;
   logic [8:0] err_sum_s;

   // Count protocol violations; bus fight and OE-in-window are mutually exclusive.
   always_comb begin
      ev_s = {1'b0, read_s && data_pins_out_en}
           + {1'b0, win_s && !OE}
           + {1'b0, commit_s && !pend_valid_q};
      err_sum_s = {1'b0, err_q} + {7'b0000000, ev_s};
      if (err_sum_s > 9'd255) begin
         err_d = 8'hFF;
      end else begin
         err_d = err_sum_s[7:0];
      end
      if (ev_s != 2'b00) begin
         contention_d = 1'b1;
      end else begin
         contention_d = contention_q;
      end
   end

   // Checker state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         contention_q <= 1'b0;
         err_q        <= 8'h00;
      end else begin
         contention_q <= contention_d;
         err_q        <= err_d;
      end
   end

   assign contention = contention_q;
   assign err_count  = err_q;
`else
   assign contention = 1'b0;
   assign err_count  = 8'h00;
`endif

endmodule
